// File: rtl/dpi_aes_cfg_responder_if.sv
// Command/response handshake between the DPI command driver and the AES config responder.
interface dpi_aes_cfg_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/dpi_aes_cfg_responder.sv
// Decodes DPI AES command words, stages key/IV in a shadow for atomic commit,
// and holds WRITE/READ bytes in a circular FIFO; one registered response per command.
module dpi_aes_cfg_responder #(
  parameter int          BUF_DEPTH = 16,
  parameter logic [31:0] SKIP_RST  = 32'd0,
  localparam int         CW        = $clog2(BUF_DEPTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  dpi_aes_cfg_responder_if.slave bus,
  output logic [127:0]        key,
  output logic [127:0]        iv,
  output logic [31:0]         skip,
  output logic                key_loaded,
  output logic                iv_loaded,
  output logic                start,
  output logic [CW-1:0]       buf_count
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_RESP} state_t;

  localparam logic [2:0] OP_KEY  = 3'd0;
  localparam logic [2:0] OP_IV   = 3'd1;
  localparam logic [2:0] OP_SKIP = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_RD   = 3'd4;
  localparam logic [2:0] OP_ENC  = 3'd5;

  localparam int            PW   = $clog2(BUF_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  state_t                    state;
  logic                      rdy;
  logic [2:0]                cur_op;
  logic [1:0]                wcnt;
  // Only words 0..2 are staged; the 4th word commits straight from the bus.
  logic [2:0][31:0]          shadow;
  logic [BUF_DEPTH-1:0][7:0] mem;
  logic [PW-1:0]             wptr, rptr;
  logic [CW-1:0]             count;
  logic                      acc, push;

  assign bus.req_ready = rdy;
  assign buf_count     = count;
  assign acc           = bus.req_valid && rdy;
  assign push          = acc && (state == S_IDLE) && (bus.req_op == OP_WR) && (count != FULL);

  // Byte storage is not reset; emptiness is tracked by count and the pointers.
  always_ff @(posedge clk)
    if (push) mem[wptr] <= bus.req_data[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rdy           <= 1'b1;
      cur_op        <= 3'd0;
      wcnt          <= 2'd0;
      shadow        <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 32'd0;
      bus.rsp_err   <= 1'b0;
      key           <= '0;
      iv            <= '0;
      skip          <= SKIP_RST;
      key_loaded    <= 1'b0;
      iv_loaded     <= 1'b0;
      start         <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: if (acc) begin
          case (bus.req_op)
            OP_KEY, OP_IV: begin
              shadow[2] <= bus.req_data;
              wcnt      <= 2'd1;
              cur_op    <= bus.req_op;
              state     <= S_COLLECT;
            end
            default: begin
              state         <= S_RESP;
              rdy           <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 32'd0;
              bus.rsp_err   <= 1'b1;
              case (bus.req_op)
                OP_SKIP: begin
                  skip        <= bus.req_data;
                  bus.rsp_err <= 1'b0;
                end
                OP_WR: begin
                  if (count != FULL) begin
                    wptr         <= wptr + 1'b1;
                    count        <= count + 1'b1;
                    bus.rsp_data <= 32'(count + 1'b1);
                    bus.rsp_err  <= 1'b0;
                  end else begin
                    bus.rsp_data <= 32'(FULL);
                  end
                end
                OP_RD: begin
                  if (count != '0) begin
                    rptr         <= rptr + 1'b1;
                    count        <= count - 1'b1;
                    bus.rsp_data <= {24'd0, mem[rptr]};
                    bus.rsp_err  <= 1'b0;
                  end
                end
                OP_ENC: begin
                  if (key_loaded && iv_loaded) begin
                    start        <= 1'b1;
                    bus.rsp_data <= 32'(count);
                    bus.rsp_err  <= 1'b0;
                  end
                end
                default: ;
              endcase
            end
          endcase
        end
        S_COLLECT: if (acc) begin
          if (bus.req_op == cur_op) begin
            if (wcnt == 2'd3) begin
              if (cur_op == OP_KEY) begin
                key        <= {shadow[2], shadow[1], shadow[0], bus.req_data};
                key_loaded <= 1'b1;
              end else begin
                iv         <= {shadow[2], shadow[1], shadow[0], bus.req_data};
                iv_loaded  <= 1'b1;
              end
              state         <= S_RESP;
              rdy           <= 1'b0;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= 32'd0;
              bus.rsp_err   <= 1'b0;
            end else begin
              shadow[2'd2 - wcnt] <= bus.req_data;
              wcnt                <= wcnt + 2'd1;
            end
          end else begin
            // Mismatched op aborts the sequence; the offending word is dropped.
            state         <= S_RESP;
            rdy           <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= {30'd0, wcnt};
            bus.rsp_err   <= 1'b1;
          end
        end
        S_RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          rdy           <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dpi_aes_cfg_responder.md
Name: dpi_aes_cfg_responder

Overview:
- Hardware-side responder for the testbench's DPI-C AES command stream: set key, set IV, set skip, write/read a byte array, trigger CBC encrypt.
- Accepts one 32-bit command word per handshake and buffers array bytes in an internal circular FIFO.
- Commits key/IV atomically to the AES core and returns exactly one registered response per completed command.
- Sits between the DPI command driver and the AES core configuration inputs.

Parameters:
BUF_DEPTH, 16, byte buffer depth; power of two, >= 2.
SKIP_RST, 0, reset value of the skip output.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  command word valid.
req_ready  output  1  responder can accept a word.
req_op  input  3  0=SET_KEY, 1=SET_IV, 2=SET_SKIP, 3=WRITE_BYTE, 4=READ_BYTE, 5=ENCRYPT, 6/7 illegal.
req_data  input  32  command payload.
rsp_valid  output  1  response valid.
rsp_ready  input  1  consumer accepts response.
rsp_data  output  32  response payload.
rsp_err  output  1  response flags an error.
key  output  128  committed AES key.
iv  output  128  committed IV.
skip  output  32  committed skip count.
key_loaded  output  1  key has been committed since reset.
iv_loaded  output  1  IV has been committed since reset.
start  output  1  single-cycle encrypt pulse.
buf_count  output  $clog2(BUF_DEPTH+1)  bytes currently held in the buffer.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, key=0, iv=0, skip=SKIP_RST, key_loaded=0, iv_loaded=0, start=0, buf_count=0, FSM=S_IDLE, buffer pointers=0.
- A word transfers when req_valid && req_ready.
- Response transfers when rsp_valid && rsp_ready.
- req_ready=1 in S_IDLE and S_COLLECT; 0 in S_RESP.
- S_IDLE, on an accepted word:
  - op 0/1: req_data goes to shadow word 0, word counter=1, next state S_COLLECT (remembering the op).
  - op 2: skip<=req_data; response data=0, err=0.
  - op 3: if buf_count<BUF_DEPTH, push req_data[7:0]; response data=new count, err=0. If full, nothing is stored; response err=1, data=BUF_DEPTH.
  - op 4: if not empty, pop; response data={24'b0, byte}, err=0. If empty: response data=0, err=1.
  - op 5: if key_loaded && iv_loaded, start=1 for exactly one cycle (the cycle after acceptance); response data=buf_count, err=0. Otherwise no start; response err=1, data=0.
  - op 6/7: response err=1, data=0; no other state changes.
  - Every non-0/1 op goes to S_RESP.
- S_COLLECT, on an accepted word:
  - Same op: word is stored at the counter index and the counter increments.
  - Word order: first word to [127:96] (high_u), then [95:64] (high_l), [63:32] (low_u), [31:0] (low_l).
  - On the 4th word: the full 128-bit shadow commits to key (op 0) or iv (op 1) in the same edge, and the matching *_loaded flag is set. Response data=0, err=0; next state S_RESP.
  - Different op: the sequence is aborted, shadow is discarded, key/iv are unchanged, and the offending word is not executed. Response err=1, data=word count collected so far (1..3); next state S_RESP.
- S_RESP:
  - rsp_valid=1 and rsp_data/rsp_err are held stable until the response transfers, then next state S_IDLE.
  - Response latency is one cycle after the accepting edge.
  - Back-to-back accepted words are at most one per two cycles for single-word ops.
- Buffer:
  - Circular with read and write pointers wrapping modulo BUF_DEPTH.
  - Push and pop never occur in the same cycle (single command per cycle).
  - buf_count is always in 0..BUF_DEPTH.
- start is never asserted outside an accepted, valid ENCRYPT.
- Reset asserted mid-operation (including S_COLLECT or S_RESP) immediately returns all outputs to reset values and empties the buffer; no partial key/IV commit occurs.

Test Plan:
- Reset, then SET_KEY words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> after the 4th word, key=0x11111111_22222222_33333333_44444444 and key_loaded=1; single response err=0; no change to key during words 1-3.
- SET_IV with 2 words then SET_SKIP 5 -> response err=1, data=2; iv=0, iv_loaded=0, skip unchanged (SKIP_RST).
- WRITE_BYTE 0xA0..0xAF (16 bytes) then a 17th write 0xB0 -> 17th response err=1, data=16. Then 16 READ_BYTE -> data 0xA0..0xAF in order. 17th read -> err=1, data=0. Repeat across pointer wrap.
- ENCRYPT before IV loaded -> err=1, start never pulses. Load IV, write 3 bytes, ENCRYPT -> start high exactly one cycle; response data=3.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data/rsp_err stable and req_ready=0 throughout. Illegal op 7 -> err=1, no state change.
- Assert rst after 2 of 4 SET_KEY words, then deassert -> key=0, key_loaded=0, FSM accepts a new SET_KEY from word 0.
